// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the fetch unit and the control decoder.
//   - opcode constants for the supported MIPS subset
//   - FSM state encoding (FETCH / EXEC / HALT)
//   - op_defined(): true for any opcode the datapath can execute
package pc_fetch_unit_pkg;

  localparam logic [5:0] OP_RTYPE    = 6'b000000;
  localparam logic [5:0] OP_ADDI     = 6'b001000;
  localparam logic [5:0] OP_BNE      = 6'b000101;
  localparam logic [5:0] OP_SLTI_ALT = 6'b101001;
  localparam logic [5:0] OP_XORI     = 6'b001110;
  localparam logic [5:0] OP_SLTI     = 6'b001010;
  localparam logic [5:0] OP_JAL      = 6'b000011;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_e;

  function automatic logic op_defined(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_ADDI, OP_BNE, OP_SLTI_ALT,
      OP_XORI, OP_SLTI, OP_JAL: return 1'b1;
      default:                  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pc_fetch_unit_next_pc_sel.sv
// Next-PC selection (purely combinational).
// Ports:
//   pc_plus4  in  32  sequential PC
//   instr_idx in  26  jump index field, instr[25:0]
//   imm_ext   in  32  extended immediate (word offset)
//   jump      in   1  control Jump (highest priority)
//   branch    in   1  control Branch
//   br_taken  in   1  ALU branch condition
//   next_pc   out 32  selected next PC
module next_pc_sel
  import pc_fetch_unit_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [25:0] instr_idx,
  input  logic [31:0] imm_ext,
  input  logic        jump,
  input  logic        branch,
  input  logic        br_taken,
  output logic [31:0] next_pc
);

  logic [31:0] jump_tgt;
  logic [31:0] br_tgt;

  // Jump stays inside the current 256 MB region of pc_plus4.
  assign jump_tgt = {pc_plus4[31:28], instr_idx, 2'b00};
  // Word offset scaled to bytes; the shift drops imm_ext[31:30], and the
  // modulo-2^32 add makes negative offsets branch backward.
  assign br_tgt   = pc_plus4 + (imm_ext << 2);

  always_comb begin
    next_pc = pc_plus4;
    if (jump)                    next_pc = jump_tgt;
    else if (branch && br_taken) next_pc = br_tgt;
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage of the single-cycle MIPS datapath. Owns the PC, fetches each
// instruction over a req/ack handshake, holds it during execute, then
// advances the PC. An undefined opcode parks the unit in HALT until reset.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   imem_req/addr/ack/rdata instruction memory handshake
//   instr, op, instr_valid  latched instruction for decode/execute
//   exec_done, jump, branch, br_taken, imm_ext   execute-side results
//   pc, pc_plus4            current PC and link value for jal
//   halted                  sticky undefined-opcode fault
//   retired                 completed-instruction counter (wraps)
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instr,
  output logic [5:0]       op,
  output logic             instr_valid,
  input  logic             exec_done,
  input  logic             jump,
  input  logic             branch,
  input  logic             br_taken,
  input  logic [31:0]      imm_ext,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        instr_q, instr_d;
  logic               imem_req_q, imem_req_d;
  logic               instr_valid_q, instr_valid_d;
  logic               halted_q, halted_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic [31:0]        next_pc;

  assign pc_plus4 = pc_q + 32'd4;

  next_pc_sel u_next_pc_sel (
    .pc_plus4  (pc_plus4),
    .instr_idx (instr_q[25:0]),
    .imm_ext   (imm_ext),
    .jump      (jump),
    .branch    (branch),
    .br_taken  (br_taken),
    .next_pc   (next_pc)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    case (state_q)
      FETCH: begin
        // imem_req_q is low for the first cycle after reset, so a stale
        // ack left over from before reset cannot be taken as a fetch.
        if (imem_req_q && imem_ack) begin
          instr_d = imem_rdata;
          state_d = op_defined(imem_rdata[31:26]) ? EXEC : HALT;
        end
      end
      EXEC: begin
        if (exec_done) begin
          pc_d      = next_pc;
          retired_d = retired_q + CNT_W'(1);
          state_d   = FETCH;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = HALT;
    endcase
    // Outputs are registered from the next state so they line up with it.
    imem_req_d    = (state_d == FETCH);
    instr_valid_d = (state_d == EXEC);
    halted_d      = (state_d == HALT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      instr_q       <= 32'd0;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      retired_q     <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      imem_req_q    <= imem_req_d;
      instr_valid_q <= instr_valid_d;
      halted_q      <= halted_d;
      retired_q     <= retired_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign op          = instr_q[31:26];
  assign instr_valid = instr_valid_q;
  assign pc          = pc_q;
  assign halted      = halted_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  op;
  logic        instr_valid;
  logic        exec_done, jump, branch, br_taken;
  logic [31:0] imm_ext;
  logic [31:0] pc, pc_plus4;
  logic        halted;
  logic [31:0] retired;

  pc_fetch_unit dut (
    .clk(clk), .reset(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr(instr), .op(op), .instr_valid(instr_valid),
    .exec_done(exec_done), .jump(jump), .branch(branch), .br_taken(br_taken),
    .imm_ext(imm_ext), .pc(pc), .pc_plus4(pc_plus4), .halted(halted),
    .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        jump, branch, br_taken;
    logic [31:0] imm;
    logic [31:0] pc, pc4, nxt;
  } vec_t;

  vec_t tbl[14];
  int   nchk = 0;
  int   errs = 0;
  logic [31:0] exp_ret = 0;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] rd, input logic j, input logic b,
                              input logic t, input logic [31:0] im, input logic [31:0] p,
                              input logic [31:0] p4, input logic [31:0] n);
    vec_t v;
    v.rdata = rd; v.jump = j; v.branch = b; v.br_taken = t; v.imm = im;
    v.pc = p; v.pc4 = p4; v.nxt = n;
    return v;
  endfunction

  initial begin
    //              rdata         j  b  t  imm            pc            pc4           next
    tbl[0]  = mk(32'h0022_1820, 0, 0, 0, 32'h0,        32'h0,        32'h4,        32'h4);
    tbl[1]  = mk(32'h0043_2020, 0, 0, 0, 32'h0,        32'h4,        32'h8,        32'h8);
    tbl[2]  = mk(32'h0064_2822, 0, 0, 0, 32'h0,        32'h8,        32'hC,        32'hC);
    tbl[3]  = mk(32'h2001_0005, 0, 0, 0, 32'h0,        32'hC,        32'h10,       32'h10);
    tbl[4]  = mk(32'h1422_FFFF, 0, 1, 1, 32'hFFFF_FFFC, 32'h10,      32'h14,       32'h4);
    tbl[5]  = mk(32'h1422_0002, 0, 1, 1, 32'h2,        32'h4,        32'h8,        32'h10);
    tbl[6]  = mk(32'h1422_FFFF, 0, 1, 0, 32'hFFFF_FFFC, 32'h10,      32'h14,       32'h14);
    tbl[7]  = mk(32'h0C10_0000, 1, 0, 0, 32'h0,        32'h14,       32'h18,       32'h0040_0000);
    tbl[8]  = mk(32'h0C00_0100, 1, 0, 0, 32'h0,        32'h0040_0000, 32'h0040_0004, 32'h400);
    tbl[9]  = mk(32'h0C00_0100, 1, 1, 1, 32'h10,       32'h400,      32'h404,      32'h400);
    tbl[10] = mk(32'h2843_0001, 0, 1, 0, 32'h10,       32'h400,      32'h404,      32'h404);
    tbl[11] = mk(32'hA443_0002, 0, 0, 0, 32'h0,        32'h404,      32'h408,      32'h408);
    tbl[12] = mk(32'h1400_FEFC, 0, 1, 1, 32'hFFFF_FEFC, 32'h408,     32'h40C,      32'hFFFF_FFFC);
    tbl[13] = mk(32'h0000_0020, 0, 0, 0, 32'h0,        32'hFFFF_FFFC, 32'h0,       32'h0);

    rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; exec_done = 1'b0;
    jump = 1'b0; branch = 1'b0; br_taken = 1'b0; imm_ext = 32'h0;
    step(); step();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_retired", retired, 32'h0);
    rst = 1'b0;

    // Table: one instruction per vector, zero-wait memory.
    for (int i = 0; i < 14; i++) begin
      int n;
      n = 0;
      while (!imem_req && n < 20) begin step(); n++; end
      chk($sformatf("v%0d_req", i), {31'd0, imem_req}, 32'd1);
      chk($sformatf("v%0d_addr", i), imem_addr, tbl[i].pc);
      imem_ack = 1'b1; imem_rdata = tbl[i].rdata;
      step();
      imem_ack = 1'b0; imem_rdata = 32'hDEAD_BEEF;
      chk($sformatf("v%0d_valid", i), {31'd0, instr_valid}, 32'd1);
      chk($sformatf("v%0d_instr", i), instr, tbl[i].rdata);
      chk($sformatf("v%0d_op", i), {26'd0, op}, {26'd0, tbl[i].rdata[31:26]});
      chk($sformatf("v%0d_pc4", i), pc_plus4, tbl[i].pc4);
      chk($sformatf("v%0d_req_exec", i), {31'd0, imem_req}, 32'd0);
      exec_done = 1'b1; jump = tbl[i].jump; branch = tbl[i].branch;
      br_taken = tbl[i].br_taken; imm_ext = tbl[i].imm;
      step();
      exec_done = 1'b0; jump = 1'b0; branch = 1'b0; br_taken = 1'b0; imm_ext = 32'h0;
      exp_ret++;
      chk($sformatf("v%0d_next_pc", i), pc, tbl[i].nxt);
      chk($sformatf("v%0d_valid_drop", i), {31'd0, instr_valid}, 32'd0);
      chk($sformatf("v%0d_req_back", i), {31'd0, imem_req}, 32'd1);
      chk($sformatf("v%0d_retired", i), retired, exp_ret);
    end

    // Delayed ack: request held 4 cycles, ack on the 4th.
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("dly%0d_req", c), {31'd0, imem_req}, 32'd1);
      chk($sformatf("dly%0d_addr", c), imem_addr, 32'h0);
      chk($sformatf("dly%0d_instr", c), instr, 32'h0000_0020);
      step();
    end
    chk("dly3_req", {31'd0, imem_req}, 32'd1);
    chk("dly3_addr", imem_addr, 32'h0);
    imem_ack = 1'b1; imem_rdata = 32'h3822_000F;
    step();
    chk("dly_valid", {31'd0, instr_valid}, 32'd1);
    chk("dly_instr", instr, 32'h3822_000F);
    // Spurious ack while executing.
    imem_rdata = 32'h0000_0000;
    step();
    imem_ack = 1'b0;
    chk("spur_instr", instr, 32'h3822_000F);
    chk("spur_valid", {31'd0, instr_valid}, 32'd1);
    chk("spur_req", {31'd0, imem_req}, 32'd0);
    exec_done = 1'b1;
    step();
    exec_done = 1'b0;
    exp_ret++;
    chk("dly_next_pc", pc, 32'h4);
    chk("dly_retired", retired, exp_ret);

    // Undefined opcode -> HALT.
    imem_ack = 1'b1; imem_rdata = 32'hFC00_0000;
    step();
    imem_ack = 1'b0;
    chk("halt_flag", {31'd0, halted}, 32'd1);
    chk("halt_req", {31'd0, imem_req}, 32'd0);
    chk("halt_valid", {31'd0, instr_valid}, 32'd0);
    exec_done = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h0000_0020;
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("halt%0d_pc", c), pc, 32'h4);
      chk($sformatf("halt%0d_req", c), {31'd0, imem_req}, 32'd0);
      chk($sformatf("halt%0d_flag", c), {31'd0, halted}, 32'd1);
      chk($sformatf("halt%0d_retired", c), retired, exp_ret);
    end
    exec_done = 1'b0; imem_ack = 1'b0;
    rst = 1'b1;
    step();
    chk("hrst_halted", {31'd0, halted}, 32'd0);
    chk("hrst_pc", pc, 32'h0);
    chk("hrst_retired", retired, 32'h0);

    // Late ack in the first cycle after reset must be ignored.
    rst = 1'b0;
    chk("late_req0", {31'd0, imem_req}, 32'd0);
    imem_ack = 1'b1; imem_rdata = 32'h0022_1820;
    step();
    chk("late_req1", {31'd0, imem_req}, 32'd1);
    chk("late_instr", instr, 32'h0);
    chk("late_valid", {31'd0, instr_valid}, 32'd0);
    step();
    imem_ack = 1'b0;
    chk("rexec_valid", {31'd0, instr_valid}, 32'd1);
    // Reset wins over exec_done in EXEC.
    exec_done = 1'b1; rst = 1'b1;
    step();
    exec_done = 1'b0; rst = 1'b0;
    chk("rexec_pc", pc, 32'h0);
    chk("rexec_retired", retired, 32'h0);
    chk("rexec_valid_clr", {31'd0, instr_valid}, 32'd0);
    chk("rexec_instr", instr, 32'h0);
    step();
    chk("rexec_req", {31'd0, imem_req}, 32'd1);
    chk("rexec_addr", imem_addr, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nchk, errs);
    $finish;
  end

endmodule
